mux_six_sequencer: RTL and testbench

- Controller that sequences the 1-to-6 operand demultiplexer of the multiplier datapath.
- On start it walks a 6-bit destination mask from lowest to highest set bit.
- For each selected destination it accepts one word over a valid/ready handshake, then drives the demux select (op), the data word and a one-cycle load strobe.
- Pulses done when the mask is exhausted.
- Sits between the operand source and the demux/destination registers a..f.

---
 rtl/mux_six_sequencer.sv | 131 +++++++++++++
 tb/tb_mux_six_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_six_sequencer.sv
// mux_six_sequencer: steps the 1-to-6 operand demux of the multiplier datapath.
// On iniciar it walks the latched destination mask from lowest to highest set
// bit. For each selected destination it takes one word over valid/ready. It then
// presents the op/saida pair with a one-cycle carrega strobe. pronto pulses once
// when the mask is exhausted.
module mux_six_sequencer #(
    parameter int LARGURA  = 16,
    parameter int NUM_DEST = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [NUM_DEST-1:0] mascara,
    input  logic [LARGURA-1:0]  entrada,
    input  logic                entrada_valida,
    output logic                entrada_pronta,
    output logic [2:0]          op,
    output logic [LARGURA-1:0]  saida,
    output logic                carrega,
    output logic                ocupado,
    output logic                pronto
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t             estado;
    estado_t             proximo;
    logic [NUM_DEST-1:0] mask_q;
    logic [NUM_DEST-1:0] restante;

    // Index of the lowest set bit of a destination mask (0 when the mask is empty)
    function automatic logic [2:0] menor_bit(input logic [NUM_DEST-1:0] m);
        logic achou;
        menor_bit = '0;
        achou     = 1'b0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            if (m[i] && !achou) begin
                menor_bit = 3'(i);
                achou     = 1'b1;
            end
        end
    endfunction

    // Mask left over once the destination currently in op has been written
    always_comb begin
        restante = mask_q & ~(NUM_DEST'(1) << op);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state decode plus the handshake/status outputs decoded from state
    always_comb begin
        proximo        = estado;
        entrada_pronta = 1'b0;
        ocupado        = 1'b1;
        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (iniciar) begin
                    proximo = (mascara != '0) ? ESPERA : FIM;
                end
            end
            ESPERA: begin
                entrada_pronta = 1'b1;
                if (entrada_valida) begin
                    proximo = ESCREVE;
                end
            end
            ESCREVE: begin
                proximo = (restante != '0) ? ESPERA : FIM;
            end
            FIM: begin
                proximo = OCIOSO;
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    // Datapath registers. The strobes are registered from the next state, so
    // carrega is high exactly during ESCREVE and pronto exactly during FIM.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q  <= '0;
            op      <= '0;
            saida   <= '0;
            carrega <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            carrega <= (proximo == ESCREVE);
            pronto  <= (proximo == FIM);
            case (estado)
                OCIOSO: begin
                    if (iniciar && (mascara != '0)) begin
                        mask_q <= mascara;
                        op     <= menor_bit(mascara);
                    end
                end
                ESPERA: begin
                    if (entrada_valida) begin
                        saida <= entrada;
                    end
                end
                ESCREVE: begin
                    mask_q <= restante;
                    op     <= (restante != '0) ? menor_bit(restante) : '0;
                end
                FIM: begin
                    op <= '0;
                end
                default: begin
                    op <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_six_sequencer.sv
// tb_mux_six_sequencer: directed scenarios for mux_six_sequencer with
// hand-computed expected load order, cycle positions and output values.
module tb_mux_six_sequencer;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic [5:0]  mascara;
    logic [15:0] entrada;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [2:0]  op;
    logic [15:0] saida;
    logic        carrega;
    logic        ocupado;
    logic        pronto;

    int errors = 0;
    int checks = 0;

    // Words offered per destination and the events recorded by run_seq.
    logic [15:0] words [6];
    logic [2:0]  ev_op [8];
    logic [15:0] ev_saida [8];
    int          ev_cyc [8];
    int          n_car, n_pronto, pronto_cyc, ocup_cnt, ep_cnt, hold_err, op_err;

    mux_six_sequencer #(.LARGURA(16), .NUM_DEST(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .mascara        (mascara),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .op             (op),
        .saida          (saida),
        .carrega        (carrega),
        .ocupado        (ocupado),
        .pronto         (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Starts an operation and runs ncyc+1 edges, acting as the operand source.
    // Edge 0 is the one that samples iniciar. gap = idle cycles before each word.
    // poke >= 0 re-pulses iniciar with a full mask after that edge.
    task automatic run_seq(input logic [5:0] m, input int gap, input int ncyc, input int poke);
        int          waited;
        logic        prev_ep;
        logic [2:0]  prev_op;
        logic [15:0] prev_saida;
        for (int k = 0; k < 8; k++) begin
            ev_op[k]    = 3'h7;
            ev_saida[k] = 16'hdead;
            ev_cyc[k]   = -1;
        end
        n_car = 0; n_pronto = 0; pronto_cyc = -1; ocup_cnt = 0;
        ep_cnt = 0; hold_err = 0; op_err = 0; waited = 0;
        prev_ep = 1'b0; prev_op = '0; prev_saida = '0;
        mascara        = m;
        iniciar        = 1'b1;
        entrada        = words[0];
        entrada_valida = (gap == 0);
        for (int e = 0; e <= ncyc; e++) begin
            step;
            if (e == 0 || e == poke + 1) begin
                iniciar = 1'b0;
                mascara = '0;
            end
            if (e == poke) begin
                iniciar = 1'b1;
                mascara = 6'h3f;
            end
            if (carrega) begin
                if (n_car < 8) begin
                    ev_op[n_car]    = op;
                    ev_saida[n_car] = saida;
                    ev_cyc[n_car]   = e;
                end
                n_car++;
                waited = 0;
            end
            if (pronto) begin
                n_pronto++;
                pronto_cyc = e;
            end
            if (ocupado) ocup_cnt++;
            if (entrada_pronta) ep_cnt++;
            if (op > 3'd5) op_err++;
            if (carrega && pronto) op_err++;
            if (!ocupado && op != 3'd0) op_err++;
            if (entrada_pronta && prev_ep && (op !== prev_op || saida !== prev_saida)) hold_err++;
            prev_ep    = entrada_pronta;
            prev_op    = op;
            prev_saida = saida;
            entrada = words[(n_car < 6) ? n_car : 5];
            if (entrada_pronta) begin
                if (waited < gap) begin
                    entrada_valida = 1'b0;
                    waited++;
                end else begin
                    entrada_valida = 1'b1;
                end
            end
        end
        entrada_valida = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; iniciar = 1'b0; mascara = '0; entrada = '0; entrada_valida = 1'b0;
        step; step;
        checks++; if ({op, saida, carrega, pronto} !== 22'd0) begin
            errors++; $display("FAIL reset_outputs: op=%0d saida=%0h carrega=%b pronto=%b, required all 0", op, saida, carrega, pronto);
        end
        checks++; if ({ocupado, entrada_pronta} !== 2'b00) begin
            errors++; $display("FAIL reset_status: ocupado=%b entrada_pronta=%b, required 0 0", ocupado, entrada_pronta);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_full;
        for (int k = 0; k < 6; k++) words[k] = 16'(k + 1);
        run_seq(6'b111111, 0, 16, -1);
        checks++; if (n_car !== 6) begin
            errors++; $display("FAIL full_count: carrega pulses=%0d, required 6", n_car);
        end
        for (int k = 0; k < 6; k++) begin
            checks++; if (ev_op[k] !== 3'(k) || ev_saida[k] !== 16'(k + 1) || ev_cyc[k] !== 2 * k + 1) begin
                errors++; $display("FAIL full_load%0d: op=%0d saida=%0d cycle=%0d, required op=%0d saida=%0d cycle=%0d",
                                   k, ev_op[k], ev_saida[k], ev_cyc[k], k, k + 1, 2 * k + 1);
            end
        end
        checks++; if (n_pronto !== 1 || pronto_cyc !== 12) begin
            errors++; $display("FAIL full_pronto: pulses=%0d edge=%0d, required 1 at edge 12", n_pronto, pronto_cyc);
        end
        checks++; if (ocup_cnt !== 13 || op_err !== 0 || hold_err !== 0) begin
            errors++; $display("FAIL full_status: ocupado_cycles=%0d op_err=%0d hold_err=%0d, required 13 0 0", ocup_cnt, op_err, hold_err);
        end
        checks++; if (saida !== 16'd6 || op !== 3'd0) begin
            errors++; $display("FAIL full_hold: saida=%0d op=%0d, required saida=6 op=0", saida, op);
        end
    endtask

    task automatic test_sparse;
        words[0] = 16'd10; words[1] = 16'd20; words[2] = 16'd30;
        words[3] = 16'd0;  words[4] = 16'd0;  words[5] = 16'd0;
        run_seq(6'b100101, 0, 10, -1);
        checks++; if (n_car !== 3) begin
            errors++; $display("FAIL sparse_count: carrega pulses=%0d, required 3", n_car);
        end
        checks++; if (ev_op[0] !== 3'd0 || ev_op[1] !== 3'd2 || ev_op[2] !== 3'd5) begin
            errors++; $display("FAIL sparse_ops: ops=%0d,%0d,%0d, required 0,2,5", ev_op[0], ev_op[1], ev_op[2]);
        end
        checks++; if (ev_saida[0] !== 16'd10 || ev_saida[1] !== 16'd20 || ev_saida[2] !== 16'd30) begin
            errors++; $display("FAIL sparse_data: saida=%0d,%0d,%0d, required 10,20,30", ev_saida[0], ev_saida[1], ev_saida[2]);
        end
        checks++; if (n_pronto !== 1 || pronto_cyc !== 6 || ev_cyc[2] !== 5) begin
            errors++; $display("FAIL sparse_pronto: pulses=%0d edge=%0d last_load=%0d, required 1 at 6 after load at 5", n_pronto, pronto_cyc, ev_cyc[2]);
        end
    endtask

    task automatic test_empty;
        run_seq(6'b000000, 0, 4, -1);
        checks++; if (n_car !== 0) begin
            errors++; $display("FAIL empty_carrega: pulses=%0d, required 0", n_car);
        end
        checks++; if (n_pronto !== 1 || pronto_cyc !== 0 || ocup_cnt !== 1) begin
            errors++; $display("FAIL empty_pronto: pulses=%0d edge=%0d ocupado_cycles=%0d, required 1 0 1", n_pronto, pronto_cyc, ocup_cnt);
        end
    endtask

    task automatic test_stall;
        words[0] = 16'h0a07; words[1] = 16'h0b08;
        run_seq(6'b000011, 4, 16, -1);
        checks++; if (n_car !== 2 || ev_cyc[0] !== 5 || ev_cyc[1] !== 11) begin
            errors++; $display("FAIL stall_loads: pulses=%0d edges=%0d,%0d, required 2 at 5,11", n_car, ev_cyc[0], ev_cyc[1]);
        end
        checks++; if (ev_op[0] !== 3'd0 || ev_op[1] !== 3'd1 || ev_saida[0] !== 16'h0a07 || ev_saida[1] !== 16'h0b08) begin
            errors++; $display("FAIL stall_data: (%0d,%0h) (%0d,%0h), required (0,a07) (1,b08)", ev_op[0], ev_saida[0], ev_op[1], ev_saida[1]);
        end
        checks++; if (ep_cnt !== 10 || hold_err !== 0 || op_err !== 0) begin
            errors++; $display("FAIL stall_wait: ready_cycles=%0d hold_err=%0d op_err=%0d, required 10 0 0", ep_cnt, hold_err, op_err);
        end
        checks++; if (n_pronto !== 1 || pronto_cyc !== 12) begin
            errors++; $display("FAIL stall_pronto: pulses=%0d edge=%0d, required 1 at 12", n_pronto, pronto_cyc);
        end
    endtask

    task automatic test_busy;
        words[0] = 16'h0055; words[1] = 16'h0066;
        run_seq(6'b000010, 3, 10, 1);
        checks++; if (n_car !== 1 || ev_op[0] !== 3'd1 || ev_saida[0] !== 16'h0055 || ev_cyc[0] !== 4) begin
            errors++; $display("FAIL busy_ignore: pulses=%0d op=%0d saida=%0h edge=%0d, required 1 op=1 saida=55 edge=4",
                               n_car, ev_op[0], ev_saida[0], ev_cyc[0]);
        end
        checks++; if (n_pronto !== 1 || pronto_cyc !== 5) begin
            errors++; $display("FAIL busy_pronto: pulses=%0d edge=%0d, required 1 at 5", n_pronto, pronto_cyc);
        end
    endtask

    task automatic test_reset_mid;
        words[0] = 16'h1234;
        entrada = words[0]; entrada_valida = 1'b0; mascara = 6'h3f; iniciar = 1'b1;
        step;
        iniciar = 1'b0; mascara = '0;
        step; step;
        checks++; if (entrada_pronta !== 1'b1 || op !== 3'd0) begin
            errors++; $display("FAIL midreset_pre: entrada_pronta=%b op=%0d, required 1 0", entrada_pronta, op);
        end
        reset = 1'b1;
        step;
        reset = 1'b0; entrada_valida = 1'b1;
        checks++; if ({op, saida, carrega, pronto, ocupado, entrada_pronta} !== 24'd0) begin
            errors++; $display("FAIL midreset_clear: op=%0d saida=%0h carrega=%b pronto=%b ocupado=%b ready=%b, required all 0",
                               op, saida, carrega, pronto, ocupado, entrada_pronta);
        end
        step;
        checks++; if ({carrega, pronto, ocupado, entrada_pronta} !== 4'd0 || saida !== 16'd0) begin
            errors++; $display("FAIL midreset_after: carrega=%b pronto=%b ocupado=%b ready=%b saida=%0h, required all 0",
                               carrega, pronto, ocupado, entrada_pronta, saida);
        end
        entrada_valida = 1'b0;
    endtask

    initial begin
        test_reset;
        test_full;
        test_sparse;
        test_empty;
        test_stall;
        test_busy;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
